imm_gen_pipe: RTL

//  Registered immediate generator for the decode stage: takes a raw 32-bit RV32I instruction word

---
 rtl/imm_pkg.sv | 16 +
 rtl/imm_format.sv | 62 ++++++
 rtl/imm_gen_pipe.sv | 76 +++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the registered RV32I immediate generator.
// Format-select encodings and skid-buffer depth.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_IZ = 3'd5
    } imm_sel_e;

    localparam int IMM_SKID_DEPTH = 2;

endpackage

// File: rtl/imm_format.sv
// Combinational RV32I immediate extraction and extension.
// The 32-bit result is formed first, then widened with the same sign/zero mode.
module imm_format
    import imm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    output logic [WIDTH-1:0] imm,
    output logic             err
);

    logic [31:0] imm32;
    logic        sext;
    logic        unused_opcode;

    // Opcode bits never contribute to any immediate.
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm32 = '0;
        sext  = 1'b0;
        err   = 1'b0;
        case (imm_sel)
            IMM_I: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                sext  = 1'b1;
            end
            IMM_S: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sext  = 1'b1;
            end
            IMM_B: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sext  = 1'b1;
            end
            IMM_U: begin
                imm32 = {instr[31:12], 12'b0};
                sext  = 1'b1;
            end
            IMM_J: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                sext  = 1'b1;
            end
            IMM_IZ: begin
                imm32 = {20'b0, instr[31:20]};
                sext  = 1'b0;
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

    if (WIDTH > 32) begin : g_wide
        assign imm = {{(WIDTH-32){sext & imm32[31]}}, imm32};
    end else begin : g_narrow
        assign imm = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer on a valid/ready pipe.
// Handshake: a beat moves when valid && ready on that side; in_ready depends only on the entry count.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] imm_out,
    output logic             imm_err
);

    logic [WIDTH-1:0] fmt_imm;
    logic             fmt_err;

    logic [WIDTH-1:0] data_q [IMM_SKID_DEPTH];
    logic             err_q  [IMM_SKID_DEPTH];
    logic             head;
    logic [1:0]       count;
    logic             wr_idx;
    logic             push;
    logic             pop;

    imm_format #(.WIDTH(WIDTH)) u_format (
        .instr   (instr),
        .imm_sel (imm_sel),
        .imm     (fmt_imm),
        .err     (fmt_err)
    );

    assign in_ready  = (count < 2'(IMM_SKID_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Next free slot sits one past the head when a single entry is held.
    assign wr_idx    = head ^ count[0];

    assign imm_out = out_valid ? data_q[head] : '0;
    assign imm_err = out_valid ? err_q[head]  : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            head      <= 1'b0;
            data_q[0] <= '0;
            data_q[1] <= '0;
            err_q[0]  <= 1'b0;
            err_q[1]  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_idx] <= fmt_imm;
                err_q[wr_idx]  <= fmt_err;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
